// File: rtl/memoria_principal_resp_if.sv
// Request/response bus between the fully-associative cache and its memory-side responder.
// The cache drives the request fields; the responder returns read data, Ready and Busy.
interface memoria_principal_resp_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 5
);
    logic              Req;
    logic              C_Write_M;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] C_Block_M;
    logic [DATA_W-1:0] M_Block_C;
    logic              Ready;
    logic              Busy;

    modport master (
        output Req,
        output C_Write_M,
        output Address,
        output C_Block_M,
        input  M_Block_C,
        input  Ready,
        input  Busy
    );

    modport slave (
        input  Req,
        input  C_Write_M,
        input  Address,
        input  C_Block_M,
        output M_Block_C,
        output Ready,
        output Busy
    );
endinterface

// File: rtl/memoria_principal_resp.sv
// Memory-side responder: one fill/write-back at a time, fixed LATENCY, one-cycle Ready pulse.
// Optional build macro MEM_PRELOAD_EN seeds the array with the cache's initial contents.
module memoria_principal_resp #(
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 5,
    parameter int unsigned LATENCY = 2
) (
    input  logic                    Clock,
    input  logic                    Reset,
    memoria_principal_resp_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef logic [DATA_W-1:0] mem_t [DEPTH];

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("memoria_principal_resp: LATENCY must be within 1..15");
        end
    endgenerate

    // Power-up image of the backing array; Reset never touches it.
    function automatic mem_t f_mem_init();
        mem_t m;
        for (int a = 0; a < int'(DEPTH); a++) begin
`ifdef MEM_PRELOAD_EN
            case (a)
                100:     m[a] = DATA_W'(5);
                101:     m[a] = DATA_W'(3);
                102:     m[a] = DATA_W'(1);
                105:     m[a] = DATA_W'(5);
                default: m[a] = DATA_W'(a[4:0]);
            endcase
`else
            m[a] = '0;
`endif
        end
        return m;
    endfunction

    mem_t r_mem = f_mem_init();

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_ready;
    logic              r_busy;

    logic [1:0]        w_state_d;
    logic [CNT_W-1:0]  w_cnt_d;
    logic [ADDR_W-1:0] w_addr_d;
    logic              w_we_d;
    logic [DATA_W-1:0] w_wdata_d;
    logic              w_ready_d;
    logic              w_busy_d;
    logic              w_commit;
    logic              w_mem_we;
    logic              w_rd_en;

    // Next-state, request capture and registered-output preparation.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_addr_d  = r_addr;
        w_we_d    = r_we;
        w_wdata_d = r_wdata;
        w_commit  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.Req) begin
                    w_addr_d  = bus.Address;
                    w_we_d    = bus.C_Write_M;
                    w_wdata_d = bus.C_Block_M;
                    w_cnt_d   = CNT_W'(LATENCY - 1);
                    w_state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end else begin
                    w_commit  = 1'b1;
                    w_state_d = S_DONE;
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        w_ready_d = (w_state_d == S_DONE);
        w_busy_d  = (w_state_d != S_IDLE);
    end

    assign w_mem_we = w_commit & r_we;
    assign w_rd_en  = w_commit & ~r_we;

    // Control and output registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_addr  <= w_addr_d;
            r_we    <= w_we_d;
            r_wdata <= w_wdata_d;
            r_ready <= w_ready_d;
            r_busy  <= w_busy_d;
            if (w_rd_en) begin
                r_rdata <= r_mem[r_addr];
            end
        end
    end

    // Array write port; a Reset on the commit edge aborts the write.
    always_ff @(posedge Clock) begin
        if (!Reset && w_mem_we) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    assign bus.M_Block_C = r_rdata;
    assign bus.Ready     = r_ready;
    assign bus.Busy      = r_busy;

endmodule

// File: tb/tb_memoria_principal_resp.sv
// Self-checking bench for memoria_principal_resp: LATENCY 2, 1 and 15 instances against a
// word-array model; build with or without MEM_PRELOAD_EN.
module tb_memoria_principal_resp;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 5;
    localparam int unsigned DEPTH  = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    memoria_principal_resp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus   ();
    memoria_principal_resp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1  ();
    memoria_principal_resp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus15 ();

    memoria_principal_resp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(2))  dut   (.Clock(clk), .Reset(rst), .bus(bus));
    memoria_principal_resp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(1))  dut1  (.Clock(clk), .Reset(rst), .bus(bus1));
    memoria_principal_resp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(15)) dut15 (.Clock(clk), .Reset(rst), .bus(bus15));

    int checks = 0;
    int errors = 0;

    // Reference model: one word array and one read-data register per instance.
    logic [DATA_W-1:0] mem_m  [DEPTH];
    logic [DATA_W-1:0] mem_1  [DEPTH];
    logic [DATA_W-1:0] mem_15 [DEPTH];
    logic [DATA_W-1:0] rd_m, rd_1, rd_15;

    function automatic logic [DATA_W-1:0] init_word(input int a);
`ifdef MEM_PRELOAD_EN
        case (a)
            100:     return 5'd5;
            101:     return 5'd3;
            102:     return 5'd1;
            105:     return 5'd5;
            default: return DATA_W'(a % 32);
        endcase
`else
        return '0;
`endif
    endfunction

    function automatic int lat_of(input int sel);
        return (sel == 1) ? 1 : (sel == 15) ? 15 : 2;
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            1:       return bus1.Busy;
            15:      return bus15.Busy;
            default: return bus.Busy;
        endcase
    endfunction

    function automatic logic get_ready(input int sel);
        case (sel)
            1:       return bus1.Ready;
            15:      return bus15.Ready;
            default: return bus.Ready;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] get_data(input int sel);
        case (sel)
            1:       return bus1.M_Block_C;
            15:      return bus15.M_Block_C;
            default: return bus.M_Block_C;
        endcase
    endfunction

    task automatic set_req(input int sel, input logic req, input logic wr,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        case (sel)
            1:       begin bus1.Req = req;  bus1.C_Write_M = wr;  bus1.Address = addr;  bus1.C_Block_M = data;  end
            15:      begin bus15.Req = req; bus15.C_Write_M = wr; bus15.Address = addr; bus15.C_Block_M = data; end
            default: begin bus.Req = req;   bus.C_Write_M = wr;   bus.Address = addr;   bus.C_Block_M = data;   end
        endcase
    endtask

    // One transaction; inputs are scrambled right after acceptance. Reports what was observed.
    task automatic do_req(input int sel, input logic wr, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data, output int lat, output int busy_cyc,
                          output int ready_cnt, output logic [DATA_W-1:0] rd);
        lat = -1; busy_cyc = 0; ready_cnt = 0; rd = '0;
        @(posedge clk); #1;
        set_req(sel, 1'b1, wr, addr, data);
        @(posedge clk); #1;
        set_req(sel, 1'b0, ~wr, ADDR_W'($urandom), DATA_W'($urandom));
        for (int i = 0; i < 40; i++) begin
            if (get_busy(sel) === 1'b1) busy_cyc++;
            if (get_ready(sel) === 1'b1) begin
                ready_cnt++;
                if (lat < 0) begin lat = i; rd = get_data(sel); end
            end
            if (get_busy(sel) !== 1'b1) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_req(0, 1'b1, 1'b1, 7'd5, 5'd9);
        set_req(1, 1'b0, 1'b0, '0, '0);
        set_req(15, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.Ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.Ready); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.Busy); end
        checks++; if (bus.M_Block_C !== 5'd0) begin errors++; $display("FAIL reset_data got %0d want 0", bus.M_Block_C); end
        set_req(0, 1'b0, 1'b0, '0, '0);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_req_ignored busy got %b want 0", bus.Busy); end
        rd_m = '0; rd_1 = '0; rd_15 = '0;
    endtask

    task automatic test_read_preload();
        int lat, bc, rc; logic [DATA_W-1:0] rd;
        do_req(0, 1'b0, 7'd101, 5'd0, lat, bc, rc, rd);
        rd_m = mem_m[101];
        checks++; if (lat != 2) begin errors++; $display("FAIL read101_latency got %0d want 2", lat); end
        checks++; if (rd !== rd_m) begin errors++; $display("FAIL read101_data got %0d want %0d", rd, rd_m); end
        checks++; if (bc != 3) begin errors++; $display("FAIL read101_busy_cycles got %0d want 3", bc); end
        checks++; if (rc != 1) begin errors++; $display("FAIL read101_ready_pulses got %0d want 1", rc); end
    endtask

    task automatic test_write_read();
        int lat, bc, rc; logic [DATA_W-1:0] rd;
        do_req(0, 1'b1, 7'd7, 5'd17, lat, bc, rc, rd);
        mem_m[7] = 5'd17;
        checks++; if (lat != 2) begin errors++; $display("FAIL write7_latency got %0d want 2", lat); end
        checks++; if (rd !== rd_m) begin errors++; $display("FAIL write7_data_held got %0d want %0d", rd, rd_m); end
        do_req(0, 1'b0, 7'd7, 5'd0, lat, bc, rc, rd);
        rd_m = mem_m[7];
        checks++; if (rd !== 5'd17) begin errors++; $display("FAIL read7_after_write got %0d want 17", rd); end
    endtask

    task automatic test_req_held();
        int n; logic [DATA_W-1:0] d;
        d = DATA_W'($urandom_range(1, 31));
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b1, 7'd20, d);
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 7'd20, 5'd0);
        n = 0;
        while (bus.Ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        mem_m[20] = d;
        checks++; if (n != 2) begin errors++; $display("FAIL held_first_latency got %0d want 2", n); end
        @(posedge clk); #1;
        checks++; if (bus.Busy !== 1'b0 || bus.Ready !== 1'b0) begin
            errors++; $display("FAIL held_idle_gap busy %b ready %b want 0 0", bus.Busy, bus.Ready); end
        @(posedge clk); #1;
        checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL held_second_accept busy got %b want 1", bus.Busy); end
        set_req(0, 1'b0, 1'b0, '0, '0);
        n = 0;
        while (bus.Ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        rd_m = mem_m[20];
        checks++; if (n != 2) begin errors++; $display("FAIL held_second_latency got %0d want 2", n); end
        checks++; if (bus.M_Block_C !== rd_m) begin errors++; $display("FAIL held_second_data got %0d want %0d", bus.M_Block_C, rd_m); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int lat, bc, rc, rhigh; logic [DATA_W-1:0] rd;
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b1, 7'd3, 5'd9);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.Busy !== 1'b0 || bus.Ready !== 1'b0) begin
            errors++; $display("FAIL abort_reset_outputs busy %b ready %b want 0 0", bus.Busy, bus.Ready); end
        rhigh = 0;
        @(posedge clk); #1;
        if (bus.Ready === 1'b1) rhigh++;
        rst = 1'b0;
        rd_m = '0; rd_1 = '0; rd_15 = '0;
        repeat (3) begin @(posedge clk); #1; if (bus.Ready === 1'b1) rhigh++; end
        checks++; if (rhigh != 0) begin errors++; $display("FAIL abort_ready_quiet got %0d pulses want 0", rhigh); end
        do_req(0, 1'b0, 7'd3, 5'd0, lat, bc, rc, rd);
        rd_m = mem_m[3];
        checks++; if (rd !== rd_m) begin errors++; $display("FAIL abort_read3 got %0d want %0d", rd, rd_m); end
    endtask

    task automatic test_latency();
        int lat, bc, rc; logic [DATA_W-1:0] rd, d;
        do_req(1, 1'b0, 7'd102, 5'd0, lat, bc, rc, rd);
        rd_1 = mem_1[102];
        checks++; if (lat != 1) begin errors++; $display("FAIL lat1_latency got %0d want 1", lat); end
        checks++; if (rd !== rd_1) begin errors++; $display("FAIL lat1_data got %0d want %0d", rd, rd_1); end
        d = DATA_W'($urandom_range(1, 31));
        do_req(1, 1'b1, 7'd50, d, lat, bc, rc, rd);
        mem_1[50] = d;
        do_req(1, 1'b0, 7'd50, 5'd0, lat, bc, rc, rd);
        rd_1 = mem_1[50];
        checks++; if (rd !== rd_1) begin errors++; $display("FAIL lat1_rw_data got %0d want %0d", rd, rd_1); end
        do_req(15, 1'b0, 7'd102, 5'd0, lat, bc, rc, rd);
        rd_15 = mem_15[102];
        checks++; if (lat != 15) begin errors++; $display("FAIL lat15_latency got %0d want 15", lat); end
        checks++; if (rd !== rd_15) begin errors++; $display("FAIL lat15_data got %0d want %0d", rd, rd_15); end
        checks++; if (bc != 16) begin errors++; $display("FAIL lat15_busy_cycles got %0d want 16", bc); end
    endtask

    task automatic test_random();
        int lat, bc, rc; logic [DATA_W-1:0] rd, d; logic [ADDR_W-1:0] a; logic wr;
        for (int t = 0; t < 24; t++) begin
            a  = ADDR_W'($urandom_range(0, 15));
            d  = DATA_W'($urandom);
            wr = 1'($urandom_range(0, 1));
            do_req(0, wr, a, d, lat, bc, rc, rd);
            if (wr) mem_m[a] = d;
            else    rd_m = mem_m[a];
            checks++; if (lat != 2 || bc != 3 || rc != 1) begin
                errors++; $display("FAIL rand%0d_timing lat %0d busy %0d ready %0d want 2 3 1", t, lat, bc, rc); end
            checks++; if (rd !== rd_m) begin
                errors++; $display("FAIL rand%0d_data wr %b addr %0d got %0d want %0d", t, wr, a, rd, rd_m); end
        end
    endtask

    task automatic test_input_change();
        int lat, bc, rc; logic [DATA_W-1:0] rd;
        do_req(0, 1'b0, 7'd100, 5'd0, lat, bc, rc, rd);
        rd_m = mem_m[100];
        checks++; if (rd !== rd_m) begin errors++; $display("FAIL read100_scrambled got %0d want %0d", rd, rd_m); end
        do_req(0, 1'b1, 7'd105, 5'd22, lat, bc, rc, rd);
        mem_m[105] = 5'd22;
        do_req(0, 1'b0, 7'd105, 5'd0, lat, bc, rc, rd);
        rd_m = mem_m[105];
        checks++; if (rd !== 5'd22) begin errors++; $display("FAIL write105_scrambled got %0d want 22", rd); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int a = 0; a < int'(DEPTH); a++) begin
            mem_m[a]  = init_word(a);
            mem_1[a]  = init_word(a);
            mem_15[a] = init_word(a);
        end
        test_reset();
        test_read_preload();
        test_write_read();
        test_req_held();
        test_reset_abort();
        test_latency();
        test_random();
        test_input_change();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
